// File: rtl/fb_pattern_writer.sv
// Framebuffer pattern generator: walks the frame in raster order on a start pulse
// and issues (address, colour) write requests under a ready/stall handshake.
module fb_pattern_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 6,
  parameter int ADDR_W     = 20,
  parameter int BAR_LOG2   = 6,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] color_a,
  input  logic [COLOR_W-1:0] color_b,
  input  logic [10:0]        px,
  input  logic [10:0]        py,
  input  logic               fb_ready,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_SOLID = 2'd0;
  localparam logic [1:0]  MODE_BARS  = 2'd1;
  localparam logic [1:0]  MODE_CHECK = 2'd2;
  localparam logic [1:0]  MODE_PIXEL = 2'd3;
  localparam logic [10:0] X_LAST     = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST     = 11'(V_RES - 1);

  state_t              state, state_d;
  logic [10:0]         x, x_d;
  logic [10:0]         y, y_d;
  logic [1:0]          mode_q, mode_d;
  logic [COLOR_W-1:0]  color_a_q, color_a_d;
  logic [COLOR_W-1:0]  color_b_q, color_b_d;
  logic [10:0]         px_q, px_d;
  logic [10:0]         py_q, py_d;
  logic                fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_d;
  logic [COLOR_W-1:0]  fb_data_d;
  logic                busy_d;
  logic                done_d;
  logic                accept;
  logic                last_pixel;

  function automatic logic [COLOR_W-1:0] pattern_color(
    input logic [1:0]         m,
    input logic [10:0]        cx,
    input logic [10:0]        cy,
    input logic [COLOR_W-1:0] ca,
    input logic [COLOR_W-1:0] cb
  );
    logic pick_b;
    pick_b = 1'b0;
    case (m)
      MODE_BARS:  pick_b = cx[BAR_LOG2];
      MODE_CHECK: pick_b = cx[CHECK_LOG2] ^ cy[CHECK_LOG2];
      default:    pick_b = 1'b0;
    endcase
    return pick_b ? cb : ca;
  endfunction

  // Single multiply used only once per frame, when a single-pixel request is latched.
  function automatic logic [ADDR_W-1:0] pixel_addr(
    input logic [10:0] cx,
    input logic [10:0] cy
  );
    logic [31:0] full;
    full = 32'(cy) * 32'(H_RES) + 32'(cx);
    return full[ADDR_W-1:0];
  endfunction

  function automatic logic pixel_in_frame(
    input logic [10:0] cx,
    input logic [10:0] cy
  );
    return (32'(cx) < 32'(H_RES)) && (32'(cy) < 32'(V_RES));
  endfunction

  assign accept     = fb_we & fb_ready;
  assign last_pixel = (mode_q == MODE_PIXEL) || ((x == X_LAST) && (y == Y_LAST));

  always_comb begin
    state_d   = state;
    x_d       = x;
    y_d       = y;
    mode_d    = mode_q;
    color_a_d = color_a_q;
    color_b_d = color_b_q;
    px_d      = px_q;
    py_d      = py_q;
    fb_we_d   = fb_we;
    fb_addr_d = fb_addr;
    fb_data_d = fb_data;
    busy_d    = busy;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = mode;
          color_a_d = color_a;
          color_b_d = color_b;
          px_d      = px;
          py_d      = py;
          x_d       = 11'd0;
          y_d       = 11'd0;
          busy_d    = 1'b1;
          if (mode == MODE_PIXEL) begin
            fb_we_d   = pixel_in_frame(px, py);
            fb_addr_d = pixel_addr(px, py);
          end else begin
            fb_we_d   = 1'b1;
            fb_addr_d = '0;
          end
          fb_data_d = pattern_color(mode, 11'd0, 11'd0, color_a, color_b);
        end
      end

      RUN: begin
        if (!fb_we) begin
          // Only reachable for an out-of-frame single pixel: nothing to write.
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (accept) begin
          if (last_pixel) begin
            state_d = FIN;
            fb_we_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (x == X_LAST) begin
              x_d = 11'd0;
              y_d = y + 11'd1;
            end else begin
              x_d = x + 11'd1;
            end
            fb_addr_d = fb_addr + ADDR_W'(1);
            fb_data_d = pattern_color(mode_q, x_d, y_d, color_a_q, color_b_q);
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        x_d     = 11'd0;
        y_d     = 11'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= 11'd0;
      y         <= 11'd0;
      mode_q    <= MODE_SOLID;
      color_a_q <= '0;
      color_b_q <= '0;
      px_q      <= 11'd0;
      py_q      <= 11'd0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      x         <= x_d;
      y         <= y_d;
      mode_q    <= mode_d;
      color_a_q <= color_a_d;
      color_b_q <= color_b_d;
      px_q      <= px_d;
      py_q      <= py_d;
      fb_we     <= fb_we_d;
      fb_addr   <= fb_addr_d;
      fb_data   <= fb_data_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Bench for fb_pattern_writer: small 8x4 frame against a queue-based model, plus a
// 1280x480 instance for single-pixel addressing.
module tb_fb_pattern_writer;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 6;
  localparam int AW = 20;
  localparam int BL = 1;
  localparam int CL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] color_a, color_b;
  logic [10:0]   px, py;
  logic          fb_ready;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data;
  logic          busy, done;

  logic          b_start;
  logic [1:0]    b_mode;
  logic [CW-1:0] b_color_a, b_color_b;
  logic [10:0]   b_px, b_py;
  logic          b_ready;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [CW-1:0] b_data;
  logic          b_busy, b_done;

  fb_pattern_writer #(.H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW),
                      .BAR_LOG2(BL), .CHECK_LOG2(CL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .color_a(color_a), .color_b(color_b), .px(px), .py(py),
    .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done));

  fb_pattern_writer #(.H_RES(1280), .V_RES(480), .COLOR_W(CW), .ADDR_W(AW),
                      .BAR_LOG2(6), .CHECK_LOG2(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
    .color_a(b_color_a), .color_b(b_color_b), .px(b_px), .py(b_py),
    .fb_ready(b_ready), .fb_we(b_we), .fb_addr(b_addr), .fb_data(b_data),
    .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the whole frame as an ordered list of expected writes.
  typedef struct packed { int addr; int data; } wr_t;
  wr_t expq[$];
  int  acc_addr[$];
  int  acc_data[$];
  bit  m_busy = 0, m_done = 0, m_we = 0;
  bit  first_pending = 0;
  int  start_cyc = 0, first_we_dly = -1, done_dly = -1, done_cnt = 0;
  int  last_acc_cyc = -1, done_seen_cyc = -1;

  function automatic int pat(int m, int x, int y, int a, int b);
    case (m)
      1:       return ((x / (1 << BL)) % 2) != 0 ? b : a;
      2:       return (((x / (1 << CL)) + (y / (1 << CL))) % 2) != 0 ? b : a;
      default: return a;
    endcase
  endfunction

  task automatic build(input int m, input int a, input int b, input int pxx, input int pyy);
    wr_t w;
    expq.delete();
    if (m == 3) begin
      if (pxx < H && pyy < V) begin
        w.addr = pyy * H + pxx; w.data = a; expq.push_back(w);
      end
    end else begin
      for (int yy = 0; yy < V; yy++)
        for (int xx = 0; xx < H; xx++) begin
          w.addr = yy * H + xx; w.data = pat(m, xx, yy, a, b); expq.push_back(w);
        end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      expq.delete();
      m_busy = 0; m_done = 0; m_we = 0; first_pending = 0;
    end else begin
      check("we", fb_we, m_we);
      if (m_we) begin
        check("addr", fb_addr, expq[0].addr);
        check("data", fb_data, expq[0].data);
      end
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (done) begin
        done_cnt++; done_dly = cyc - start_cyc; done_seen_cyc = cyc;
      end
      if (fb_we && first_pending) begin
        first_we_dly = cyc - start_cyc; first_pending = 0;
      end
      if (fb_we && fb_ready) begin
        acc_addr.push_back(int'(fb_addr)); acc_data.push_back(int'(fb_data));
        last_acc_cyc = cyc + 1;
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (start) begin
          build(int'(mode), int'(color_a), int'(color_b), int'(px), int'(py));
          m_busy = 1; m_we = (expq.size() > 0);
          start_cyc = cyc; first_pending = 1;
        end
      end else if (!m_we) begin
        m_busy = 0; m_done = 1;
      end else if (fb_ready) begin
        void'(expq.pop_front());
        if (expq.size() == 0) begin
          m_we = 0; m_busy = 0; m_done = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int m, input int a, input int b, input int pxx, input int pyy,
                           input bit rnd, input int inj_at);
    acc_addr.delete(); acc_data.delete();
    done_cnt = 0; first_we_dly = -1; done_dly = -1;
    mode = 2'(m); color_a = CW'(a); color_b = CW'(b); px = 11'(pxx); py = 11'(pyy);
    fb_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == inj_at) begin
        start = 1'b1; mode = 2'd2; color_a = 6'd7; color_b = 6'd4;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; fb_ready = 1'b1;
    tick(); tick();
    check("done_count", done_cnt, 1);
    check("busy_after", busy, 0);
  endtask

  task automatic run_b(input int pxx, input int pyy, input int a,
                       output int nw, output int wa, output int wd, output int dd);
    b_mode = 2'd3; b_px = 11'(pxx); b_py = 11'(pyy); b_color_a = CW'(a); b_color_b = 6'd9;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    nw = 0; wa = -1; wd = -1; dd = -1;
    for (int i = 1; i <= 6; i++) begin
      if (b_we) begin nw++; wa = int'(b_addr); wd = int'(b_data); end
      if (b_done && dd < 0) dd = i;
      tick();
    end
  endtask

  int line_bars[8] = '{1, 1, 5, 5, 1, 1, 5, 5};
  int line_chk[8]  = '{5, 5, 1, 1, 5, 5, 1, 1};
  int nw, wa, wd, dd;

  initial begin
    rst_n = 1'b1; start = 1'b0; mode = 2'd0; color_a = '0; color_b = '0;
    px = '0; py = '0; fb_ready = 1'b1;
    b_start = 1'b0; b_mode = 2'd0; b_color_a = '0; b_color_b = '0;
    b_px = '0; b_py = '0; b_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b_rst_we", b_we, 0);
    check("b_rst_busy", b_busy, 0);
    rst_n = 1'b1;
    tick();

    // Solid fill, no stalls.
    run_frame(0, 2, 0, 0, 0, 1'b0, -1);
    check("solid_count", acc_addr.size(), 32);
    for (int i = 0; i < 32 && i < acc_addr.size(); i++) begin
      check("solid_addr", acc_addr[i], i);
      check("solid_data", acc_data[i], 2);
    end
    check("first_we_latency", first_we_dly, 1);
    check("solid_done_latency", done_dly, 33);

    // Vertical bars, line 0.
    run_frame(1, 1, 5, 0, 0, 1'b0, -1);
    for (int i = 0; i < 8 && i < acc_data.size(); i++) check("bars_line0", acc_data[i], line_bars[i]);

    // Checkerboard, line 2.
    run_frame(2, 1, 5, 0, 0, 1'b0, -1);
    for (int i = 0; i < 8 && 16 + i < acc_data.size(); i++) check("check_line2", acc_data[16 + i], line_chk[i]);

    // Random stalls.
    run_frame(0, 3, 0, 0, 0, 1'b1, -1);
    check("stall_count", acc_addr.size(), 32);
    for (int i = 0; i < 32 && i < acc_addr.size(); i++) check("stall_order", acc_addr[i], i);
    check("stall_done_gap", done_seen_cyc - last_acc_cyc, 0);

    // Start pulsed mid-frame is ignored.
    run_frame(0, 2, 0, 0, 0, 1'b0, 5);
    check("midstart_count", acc_data.size(), 32);
    for (int i = 0; i < acc_data.size(); i++) check("midstart_data", acc_data[i], 2);

    // Single pixel on the small frame: (3,2) -> 19.
    run_frame(3, 9, 1, 3, 2, 1'b0, -1);
    check("px_count", acc_addr.size(), 1);
    if (acc_addr.size() > 0) begin
      check("px_addr", acc_addr[0], 19);
      check("px_data", acc_data[0], 9);
    end
    check("px_done_latency", done_dly, 2);

    // Reset at pixel 10.
    acc_addr.delete(); acc_data.delete(); done_cnt = 0;
    mode = 2'd0; color_a = 6'd4; fb_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && acc_addr.size() < 10; i++) tick();
    check("pre_reset_addr", fb_addr, 10);
    rst_n = 1'b0;
    #1;
    check("async_we", fb_we, 0);
    check("async_addr", fb_addr, 0);
    check("async_data", fb_data, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("reset_no_done", done_cnt, 0);
    run_frame(0, 6, 0, 0, 0, 1'b0, -1);
    check("restart_count", acc_addr.size(), 32);
    if (acc_addr.size() > 0) check("restart_addr0", acc_addr[0], 0);

    // Large frame single pixel: in range, then out of range.
    run_b(1277, 0, 2, nw, wa, wd, dd);
    check("b_writes", nw, 1);
    check("b_addr", wa, 1277);
    check("b_data", wd, 2);
    check("b_done_latency", dd, 2);
    run_b(5, 3, 7, nw, wa, wd, dd);
    check("b_addr_row3", wa, 3845);
    run_b(1280, 0, 2, nw, wa, wd, dd);
    check("b_oor_writes", nw, 0);
    check("b_oor_done_latency", dd, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
